snn_run_sequencer: RTL and testbench



---
 rtl/snn_run_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_snn_run_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_run_sequencer.sv
// Run sequencer for the spiking core: frame buffer, network reset pulse, frame playback, spike counting, argmax.
// Optional abort input is enabled by defining SNN_SEQ_ABORT_EN.
module snn_run_sequencer #(
   parameter int N_IN  = 16,
   parameter int N_OUT = 8,
   parameter int DEPTH = 16,
   parameter int CNT_W = 8,
   parameter int PER_W = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int OW   = $clog2(N_OUT)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [N_IN-1:0]  cfg_data,
   input  logic [AW:0]      num_frames,
   input  logic [PER_W-1:0] step_period,
   input  logic             start,
   output logic             net_reset,
   output logic [N_IN-1:0]  net_in,
   input  logic [N_OUT-1:0] net_out_spk,
   output logic             busy,
   output logic             done,
   output logic [OW-1:0]    winner,
   output logic             winner_valid,
   input  logic [OW-1:0]    cnt_sel,
   output logic [CNT_W-1:0] cnt_out
`ifdef SNN_SEQ_ABORT_EN
   ,
   input  logic             abort
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_NRST, S_RUN, S_TAIL, S_ARGMAX, S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic             nrst_ph_q, nrst_ph_d;
   logic [AW:0]      frames_q, frames_d;
   logic [AW:0]      fidx_q, fidx_d;
   logic [PER_W-1:0] period_q, period_d;
   logic [PER_W-1:0] per_q, per_d;
   logic [OW-1:0]    scan_q, scan_d;
   logic [OW-1:0]    best_idx_q, best_idx_d;
   logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
   logic [CNT_W-1:0] cnt_q [N_OUT];
   logic [CNT_W-1:0] cnt_d [N_OUT];
   logic             net_reset_q, net_reset_d;
   logic [N_IN-1:0]  net_in_q, net_in_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [OW-1:0]    winner_q, winner_d;
   logic             wv_q, wv_d;

   logic [N_IN-1:0]  mem [DEPTH];
   logic [AW-1:0]    rd_addr;
   logic             count_en;
   logic             abort_req;

`ifdef SNN_SEQ_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // Buffer has no reset so frames survive a core reset; locked while a run is in flight.
   always_ff @(posedge clk) begin
      if (cfg_we && !busy_q) begin
         mem[cfg_addr] <= cfg_data;
      end
   end

   always_comb begin
      state_d     = state_q;
      nrst_ph_d   = nrst_ph_q;
      frames_d    = frames_q;
      fidx_d      = fidx_q;
      period_d    = period_q;
      per_d       = per_q;
      scan_d      = scan_q;
      best_idx_d  = best_idx_q;
      best_cnt_d  = best_cnt_q;
      net_reset_d = net_reset_q;
      net_in_d    = net_in_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      winner_d    = winner_q;
      wv_d        = wv_q;
      rd_addr     = fidx_q[AW-1:0] + AW'(1);
      count_en    = (state_q == S_RUN) || (state_q == S_TAIL);

      for (int i = 0; i < N_OUT; i++) begin
         cnt_d[i] = cnt_q[i];
         if (count_en && net_out_spk[i] && (cnt_q[i] != '1)) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_NRST;
               nrst_ph_d   = 1'b0;
               frames_d    = num_frames;
               period_d    = (step_period == '0) ? PER_W'(1) : step_period;
               net_reset_d = 1'b1;
               busy_d      = 1'b1;
               wv_d        = 1'b0;
               for (int i = 0; i < N_OUT; i++) begin
                  cnt_d[i] = '0;
               end
            end
         end
         S_NRST: begin
            if (!nrst_ph_q) begin
               nrst_ph_d = 1'b1;
            end else begin
               net_reset_d = 1'b0;
               per_d       = '0;
               fidx_d      = '0;
               if (frames_q == '0) begin
                  state_d  = S_TAIL;
                  net_in_d = '0;
               end else begin
                  state_d  = S_RUN;
                  net_in_d = mem['0];
               end
            end
         end
         S_RUN: begin
            if (per_q == period_q - PER_W'(1)) begin
               per_d = '0;
               if (fidx_q == frames_q - (AW+1)'(1)) begin
                  state_d  = S_TAIL;
                  net_in_d = '0;
               end else begin
                  fidx_d   = fidx_q + (AW+1)'(1);
                  net_in_d = mem[rd_addr];
               end
            end else begin
               per_d = per_q + PER_W'(1);
            end
         end
         S_TAIL: begin
            if (per_q == period_q - PER_W'(1)) begin
               state_d    = S_ARGMAX;
               scan_d     = '0;
               best_idx_d = '0;
               best_cnt_d = '0;
            end else begin
               per_d = per_q + PER_W'(1);
            end
         end
         S_ARGMAX: begin
            // Strictly-greater replacement keeps the lowest index on ties.
            if (cnt_q[scan_q] > best_cnt_q) begin
               best_idx_d = scan_q;
               best_cnt_d = cnt_q[scan_q];
            end
            if (scan_q == OW'(N_OUT - 1)) begin
               state_d  = S_DONE;
               winner_d = best_idx_d;
               done_d   = 1'b1;
               wv_d     = 1'b1;
               busy_d   = 1'b0;
            end else begin
               scan_d = scan_q + OW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort_req && busy_q) begin
         state_d     = S_IDLE;
         net_reset_d = 1'b0;
         net_in_d    = '0;
         busy_d      = 1'b0;
         done_d      = 1'b0;
         wv_d        = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         nrst_ph_q   <= 1'b0;
         frames_q    <= '0;
         fidx_q      <= '0;
         period_q    <= PER_W'(1);
         per_q       <= '0;
         scan_q      <= '0;
         best_idx_q  <= '0;
         best_cnt_q  <= '0;
         cnt_q       <= '{default: '0};
         net_reset_q <= 1'b0;
         net_in_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         winner_q    <= '0;
         wv_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         nrst_ph_q   <= nrst_ph_d;
         frames_q    <= frames_d;
         fidx_q      <= fidx_d;
         period_q    <= period_d;
         per_q       <= per_d;
         scan_q      <= scan_d;
         best_idx_q  <= best_idx_d;
         best_cnt_q  <= best_cnt_d;
         cnt_q       <= cnt_d;
         net_reset_q <= net_reset_d;
         net_in_q    <= net_in_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         winner_q    <= winner_d;
         wv_q        <= wv_d;
      end
   end

   assign net_reset    = net_reset_q;
   assign net_in       = net_in_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign winner       = winner_q;
   assign winner_valid = wv_q;
   assign cnt_out      = cnt_q[cnt_sel];

endmodule

// File: tb/tb_snn_run_sequencer.sv
// Scoreboard bench for snn_run_sequencer: stimulus pushes per-cycle and end-of-run expectations, a negedge monitor checks them.
module tb_snn_run_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [15:0] cfg_data;
   logic [4:0]  num_frames;
   logic [7:0]  step_period;
   logic        start;
   logic        net_reset;
   logic [15:0] net_in;
   logic [7:0]  net_out_spk;
   logic        busy;
   logic        done;
   logic [2:0]  winner;
   logic        winner_valid;
   logic [2:0]  cnt_sel;
   logic [7:0]  cnt_out;
`ifdef SNN_SEQ_ABORT_EN
   logic        abort;
`endif

   int cyc    = 0;
   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int cyc;
      bit nr, bz, dn, wv;
      logic [15:0] ni;
      bit snap;
      logic [2:0] win;
      logic [7:0][7:0] cnt;
   } tr_t;

   typedef struct {
      int cyc;
      logic [2:0] win;
      logic [7:0][7:0] cnt;
   } run_t;

   tr_t  tr_q[$];
   run_t run_q[$];

   snn_run_sequencer #(
      .N_IN(16), .N_OUT(8), .DEPTH(16), .CNT_W(8), .PER_W(8)
   ) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .num_frames(num_frames), .step_period(step_period), .start(start),
      .net_reset(net_reset), .net_in(net_in), .net_out_spk(net_out_spk),
      .busy(busy), .done(done), .winner(winner), .winner_valid(winner_valid),
      .cnt_sel(cnt_sel), .cnt_out(cnt_out)
`ifdef SNN_SEQ_ABORT_EN
      , .abort(abort)
`endif
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: cycle c is the one that follows clock edge c-1, sampled at its falling edge.
   always @(negedge clk) begin : mon
      int cur;
      bit need;
      logic [7:0] rd [8];
      tr_t e;
      run_t r;
      cur  = cyc + 1;
      need = done || (tr_q.size() > 0 && tr_q[0].cyc == cur && tr_q[0].snap);
      if (need) begin
         for (int i = 0; i < 8; i++) begin
            cnt_sel = 3'(i);
            #1;
            rd[i] = cnt_out;
         end
      end
      cnt_sel = 3'd0;
      while (tr_q.size() > 0 && tr_q[0].cyc < cur) begin
         e = tr_q.pop_front();
         chk($sformatf("c%0d trace_missed", e.cyc), 32'(cur), 32'(e.cyc));
      end
      if (tr_q.size() > 0 && tr_q[0].cyc == cur) begin
         e = tr_q.pop_front();
         chk($sformatf("c%0d net_reset", cur), 32'(net_reset), 32'(e.nr));
         chk($sformatf("c%0d busy", cur), 32'(busy), 32'(e.bz));
         chk($sformatf("c%0d done", cur), 32'(done), 32'(e.dn));
         chk($sformatf("c%0d winner_valid", cur), 32'(winner_valid), 32'(e.wv));
         chk($sformatf("c%0d net_in", cur), 32'(net_in), 32'(e.ni));
         if (e.snap) begin
            chk($sformatf("c%0d winner", cur), 32'(winner), 32'(e.win));
            for (int i = 0; i < 8; i++)
               chk($sformatf("c%0d cnt[%0d]", cur, i), 32'(rd[i]), 32'(e.cnt[i]));
         end
      end
      if (done) begin
         if (run_q.size() == 0) begin
            chk($sformatf("c%0d unexpected_done", cur), 32'(done), 32'd0);
         end else begin
            r = run_q.pop_front();
            chk("done_cycle", 32'(cur), 32'(r.cyc));
            chk($sformatf("c%0d run_winner", cur), 32'(winner), 32'(r.win));
            chk($sformatf("c%0d run_winner_valid", cur), 32'(winner_valid), 32'd1);
            for (int i = 0; i < 8; i++)
               chk($sformatf("c%0d run_cnt[%0d]", cur, i), 32'(rd[i]), 32'(r.cnt[i]));
         end
      end else if (run_q.size() > 0 && cur > run_q[0].cyc) begin
         r = run_q.pop_front();
         chk($sformatf("c%0d done_missing", r.cyc), 32'(done), 32'd1);
      end
   end

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   task automatic start_run(input int f, input int p, input bit hold, output int t);
      num_frames = 5'(f); step_period = 8'(p); start = 1'b1;
      @(posedge clk);
      #1;
      t = cyc;
      if (!hold) start = 1'b0;
   endtask

   task automatic push_tr(input int c, input bit nr, input bit bz, input bit dn, input bit wv,
                          input logic [15:0] ni);
      tr_t e;
      e.cyc = c; e.nr = nr; e.bz = bz; e.dn = dn; e.wv = wv; e.ni = ni;
      e.snap = 1'b0; e.win = '0; e.cnt = '0;
      tr_q.push_back(e);
   endtask

   task automatic push_snap(input int c, input bit nr, input bit bz, input bit wv, input logic [15:0] ni,
                            input logic [2:0] win, input logic [7:0][7:0] cnt);
      tr_t e;
      e.cyc = c; e.nr = nr; e.bz = bz; e.dn = 1'b0; e.wv = wv; e.ni = ni;
      e.snap = 1'b1; e.win = win; e.cnt = cnt;
      tr_q.push_back(e);
   endtask

   task automatic push_run(input int c, input logic [2:0] win, input logic [7:0][7:0] cnt);
      run_t r;
      r.cyc = c; r.win = win; r.cnt = cnt;
      run_q.push_back(r);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int t;
      logic [15:0] ni;
      logic [7:0][7:0] c;
      reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      num_frames = '0; step_period = '0; start = 1'b0; net_out_spk = '0;
`ifdef SNN_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      push_snap(cyc + 1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, '0);

      cfg_write(4'd0, 16'h00FF);
      cfg_write(4'd1, 16'hFF00);
      for (int i = 2; i < 16; i++) cfg_write(4'(i), 16'(i * 16'h1111));

      // Two frames, period 3: full per-cycle trace.
      start_run(2, 3, 1'b0, t);
      for (int k = 1; k <= 21; k++) begin
         ni = (k >= 3 && k <= 5) ? 16'h00FF : (k >= 6 && k <= 8) ? 16'hFF00 : 16'h0000;
         push_tr(t + k, k <= 2, k <= 19, k == 20, k >= 20, ni);
      end
      push_run(t + 20, 3'd0, '0);
      wait_cyc(t + 22);

      // Tie between neurons 2 and 5 resolves to the lower index.
      start_run(2, 3, 1'b0, t);
      push_tr(t + 1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      c = '0; c[2] = 8'd5; c[5] = 8'd5;
      push_run(t + 20, 3'd2, c);
      wait_cyc(t + 2);
      net_out_spk = 8'b0010_0100;
      wait_cyc(t + 7);
      net_out_spk = 8'h00;
      wait_cyc(t + 22);

      // Saturation: 320 counting cycles on neuron 7.
      net_out_spk = 8'h80;
      start_run(15, 20, 1'b0, t);
      c = '0; c[7] = 8'd255;
      push_run(t + 331, 3'd7, c);
      wait_cyc(t + 333);
      net_out_spk = 8'h00;

      // Reset during RUN clears counters, winner and outputs.
      net_out_spk = 8'h08;
      start_run(2, 3, 1'b0, t);
      push_tr(t + 1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      c = '0; c[3] = 8'd1;
      push_snap(t + 4, 1'b0, 1'b1, 1'b0, 16'h00FF, 3'd7, c);
      wait_cyc(t + 4);
      reset = 1'b1;
      wait_cyc(t + 5);
      reset = 1'b0;
      push_snap(t + 6, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, '0);
      wait_cyc(t + 8);
      net_out_spk = 8'h00;

`ifdef SNN_SEQ_ABORT_EN
      // Abort keeps partial counts (cycles t+3..t+5 counted).
      net_out_spk = 8'h08;
      start_run(2, 3, 1'b0, t);
      wait_cyc(t + 4);
      abort = 1'b1;
      wait_cyc(t + 5);
      abort = 1'b0;
      c = '0; c[3] = 8'd3;
      push_snap(t + 6, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, c);
      wait_cyc(t + 8);
      net_out_spk = 8'h00;
`endif

      // F=0, P=0: one TAIL cycle is the only counting cycle.
      net_out_spk = 8'h01;
      start_run(0, 0, 1'b0, t);
      push_tr(t + 1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      push_tr(t + 2, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      push_tr(t + 3, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      push_tr(t + 12, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
      c = '0; c[0] = 8'd1;
      push_run(t + 12, 3'd0, c);
      wait_cyc(t + 14);
      net_out_spk = 8'h00;

      // Write protect during run, start held high for back-to-back runs.
      start_run(1, 2, 1'b1, t);
      push_tr(t + 3, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00FF);
      push_tr(t + 4, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00FF);
      push_tr(t + 15, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
      push_tr(t + 16, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      push_tr(t + 17, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      push_tr(t + 19, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00FF);
      push_tr(t + 20, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00FF);
      push_tr(t + 21, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      push_run(t + 15, 3'd0, '0);
      push_run(t + 31, 3'd0, '0);
      wait_cyc(t + 3);
      cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 16'hAAAA;
      wait_cyc(t + 4);
      cfg_we = 1'b0;
      wait_cyc(t + 16);
      start = 1'b0;
      wait_cyc(t + 34);

      chk("trace_queue_drained", 32'(tr_q.size()), 32'd0);
      chk("run_queue_drained", 32'(run_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
